// File: rtl/prio_mux_sched.sv
// Frame scheduler issuing one priority-encoded select per cycle to a 32:1 registered mux.
// Define PRIO_MUX_SCHED_RR_EN for a round-robin encoder; default is fixed lowest-index priority.
module prio_mux_sched #(
    parameter int MAX_GRANTS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] req,
    input  logic        out_ready,
    output logic [4:0]  sel,
    output logic        sel_vld,
    output logic        o_vld,
    output logic [4:0]  o_idx,
    output logic        o_last,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pending;
    logic [5:0]  r_gcnt;
    logic        r_zdone;
    logic        w_stall;
    logic        w_accept;
    logic        w_last;
    logic        w_adv;
    logic        w_start_ok;
    logic [4:0]  w_enc;

    function automatic logic [4:0] lowest(input logic [31:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) idx = 5'(k);
        end
        return idx;
    endfunction

`ifdef PRIO_MUX_SCHED_RR_EN
    logic [4:0]  r_ptr;
    logic [31:0] w_rot;

    // Rotate so the pointer position becomes bit 0, then undo the offset.
    assign w_rot = (r_pending >> r_ptr)
                 | (r_pending << (6'd32 - {1'b0, r_ptr}));
    assign w_enc = lowest(w_rot) + r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 5'd0;
        end else if (w_accept && o_last) begin
            r_ptr <= o_idx + 5'd1;
        end
    end
`else
    assign w_enc = lowest(r_pending);
`endif

    assign busy       = (r_state != IDLE);
    assign sel_vld    = (r_state == SCAN);
    assign sel        = sel_vld ? w_enc : 5'd0;
    assign w_stall    = o_vld & ~out_ready;
    assign w_accept   = o_vld & out_ready;
    assign w_adv      = sel_vld & ~w_stall;
    assign w_start_ok = (r_state == IDLE) & start;
    assign w_last     = ((r_pending & (r_pending - 32'd1)) == 32'd0)
                      || (r_gcnt == 6'(MAX_GRANTS - 1));
    assign done       = r_zdone | (w_accept & o_last);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start && req != 32'd0) w_next = SCAN;
            SCAN:    if (w_adv && w_last) w_next = DRAIN;
            DRAIN:   if (w_accept && o_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pending <= 32'd0;
            r_gcnt    <= 6'd0;
            r_zdone   <= 1'b0;
            o_vld     <= 1'b0;
            o_idx     <= 5'd0;
            o_last    <= 1'b0;
            count     <= 6'd0;
        end else begin
            r_state <= w_next;
            r_zdone <= w_start_ok && (req == 32'd0);
            if (w_start_ok) begin
                r_pending <= req;
                r_gcnt    <= 6'd0;
            end else if (w_adv) begin
                r_pending <= r_pending & ~(32'd1 << sel);
                r_gcnt    <= r_gcnt + 6'd1;
            end
            // Output stage mirrors the mux register: frozen while stalled.
            if (!w_stall) begin
                o_vld  <= sel_vld;
                o_idx  <= sel;
                o_last <= sel_vld & w_last;
            end
            if (w_start_ok) begin
                count <= 6'd0;
            end else if (w_accept) begin
                count <= count + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_prio_mux_sched.sv
// Scoreboard bench for prio_mux_sched: two instances (MAX_GRANTS 32 and 2) share stimulus.
// A queue-based grant model feeds expected beats; a negedge monitor checks them.
module tb_prio_mux_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] req;
    logic        out_ready;

    logic [4:0] sel_a, sel_b, oidx_a, oidx_b;
    logic       sv_a, sv_b, ov_a, ov_b, ol_a, ol_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [5:0] cnt_a, cnt_b;

    int vecs = 0;
    int errs = 0;
    int qa[$];
    int qb[$];
    bit act[2];
    int ptr_m[2];
    int exp_n[2];

    always #5 clk = ~clk;

    prio_mux_sched #(.MAX_GRANTS(32)) u_a (
        .clk(clk), .rst(rst), .start(start), .req(req),
        .out_ready(out_ready), .sel(sel_a), .sel_vld(sv_a),
        .o_vld(ov_a), .o_idx(oidx_a), .o_last(ol_a),
        .busy(busy_a), .done(done_a), .count(cnt_a)
    );

    prio_mux_sched #(.MAX_GRANTS(2)) u_b (
        .clk(clk), .rst(rst), .start(start), .req(req),
        .out_ready(out_ready), .sel(sel_b), .sel_vld(sv_b),
        .o_vld(ov_b), .o_idx(oidx_b), .o_last(ol_b),
        .busy(busy_b), .done(done_b), .count(cnt_b)
    );

    task automatic chk(input int d, input string name,
                       input int got, input int want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s[dut%0d]: got %0d, expected %0d",
                     name, d, got, want);
        end
    endtask

    function automatic int maxg(input int d);
        return (d == 0) ? 32 : 2;
    endfunction

    function automatic void pushq(input int d, input int e);
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endfunction

    function automatic int popq(input int d);
        if (d == 0) return qa.pop_front();
        return qb.pop_front();
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    // Expected grant order: walk indices from the pointer (or 0), take up to the cap.
    task automatic model(input int d, input logic [31:0] r);
        int g[$];
        int k;
        for (int s = 0; s < 32; s++) begin
`ifdef PRIO_MUX_SCHED_RR_EN
            k = (ptr_m[d] + s) % 32;
`else
            k = s;
`endif
            if (r[k] && g.size() < maxg(d)) g.push_back(k);
        end
        for (int i = 0; i < g.size(); i++)
            pushq(d, g[i] + ((i == g.size() - 1) ? 32 : 0));
        exp_n[d] = g.size();
        if (g.size() > 0) ptr_m[d] = (g[g.size() - 1] + 1) % 32;
    endtask

    task automatic chk_zero(input string name);
        chk(0, name, {sel_a, sv_a, ov_a, oidx_a, ol_a,
                      busy_a, done_a, cnt_a}, 0);
        chk(1, name, {sel_b, sv_b, ov_b, oidx_b, ol_b,
                      busy_b, done_b, cnt_b}, 0);
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low at T+2..T+4
    task automatic run_frame(input logic [31:0] r, input int mode);
        int lat;
        bit seen[2];
        int latv[2];
        seen = '{0, 0};
        latv = '{0, 0};
        model(0, r);
        model(1, r);
        act = '{1, 1};
        @(posedge clk); #1;
        start = 1'b1;
        req = r;
        out_ready = 1'b1;
        lat = 0;
        while (!(seen[0] && seen[1]) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
            for (int d = 0; d < 2; d++) if (seen[d]) act[d] = 0;
            start = 1'b0;
            req = $urandom;
            if (busy_a && busy_b && $urandom_range(0, 3) == 0) start = 1'b1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(lat >= 2 && lat <= 4);
            endcase
            @(negedge clk);
            if (done_a && !seen[0]) begin seen[0] = 1; latv[0] = lat; end
            if (done_b && !seen[1]) begin seen[1] = 1; latv[1] = lat; end
        end
        chk(0, "done_seen", int'(seen[0]), 1);
        chk(1, "done_seen", int'(seen[1]), 1);
        if (mode == 0) begin
            chk(0, "done_latency", latv[0], exp_n[0] + 1);
            chk(1, "done_latency", latv[1], exp_n[1] + 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b1;
        act = '{0, 0};
        @(negedge clk);
        chk(0, "count", int'(cnt_a), exp_n[0]);
        chk(1, "count", int'(cnt_b), exp_n[1]);
        chk(0, "busy_after", int'(busy_a), 0);
        chk(1, "busy_after", int'(busy_b), 0);
    endtask

    task automatic reset_test();
        model(0, 32'hFF);
        model(1, 32'hFF);
        act = '{1, 1};
        @(posedge clk); #1;
        start = 1'b1;
        req = 32'hFF;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        qa.delete();
        qb.delete();
        act = '{0, 0};
        ptr_m = '{0, 0};
        @(negedge clk);
        chk_zero("mid_frame_reset");
        repeat (4) @(posedge clk);
    endtask

    initial begin
        bit ps[2];
        logic [4:0] pidx[2];
        ps = '{0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic v, l, dn, bz, sv;
                logic [4:0] ix;
                int e;
                v  = d ? ov_b : ov_a;
                l  = d ? ol_b : ol_a;
                dn = d ? done_b : done_a;
                bz = d ? busy_b : busy_a;
                sv = d ? sv_b : sv_a;
                ix = d ? oidx_b : oidx_a;
                if (rst) begin
                    ps[d] = 0;
                    continue;
                end
                if (ps[d]) begin
                    chk(d, "stall_hold_vld", int'(v), 1);
                    chk(d, "stall_hold_idx", int'(ix), int'(pidx[d]));
                end
                if (v && out_ready) begin
                    if (qsize(d) == 0) begin
                        chk(d, "unexpected_beat", int'(ix), -1);
                    end else begin
                        e = popq(d);
                        chk(d, "beat_idx", int'(ix), e % 32);
                        chk(d, "beat_last", int'(l), e / 32);
                    end
                end
                if (dn) begin
                    chk(d, "done_expected", int'(act[d]), 1);
                    chk(d, "done_all_beats", qsize(d), 0);
                end
                if (!bz) chk(d, "sel_vld_idle", int'(sv), 0);
                ps[d] = v && !out_ready;
                pidx[d] = ix;
            end
        end
    end

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        start = 1'b0;
        req = 32'd0;
        out_ready = 1'b1;
        act = '{0, 0};
        ptr_m = '{0, 0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset_state");

        run_frame(32'h0000_0025, 0);
        run_frame(32'h0000_0003, 2);
        run_frame(32'h0000_0000, 0);
        run_frame(32'hF000_0001, 0);
        run_frame(32'h0000_000F, 0);
        run_frame(32'h0000_000F, 0);
        reset_test();
        run_frame(32'h0000_0025, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: r = 32'd0;
                1: r = 32'd1 << $urandom_range(0, 31);
                2: r = $urandom;
                3: r = 32'h8000_0000 | 32'd1;
                default: r = $urandom & $urandom & $urandom;
            endcase
            run_frame(r, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
